mag_feeder: RTL and testbench

MAG_FEEDER -- requirements
Module: mag_feeder

---
 rtl/mag_feeder.sv | 195 +++++++++++++++++++
 tb/tb_mag_feeder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_feeder.sv
//==============================================================================
// Module      : mag_feeder
// Description : Buffers signed (X,Y) samples in a small FIFO and feeds the
//               squared magnitude X*X+Y*Y, one sample at a time, to a
//               downstream square-root stage. A handshake FSM issues a
//               one-cycle start pulse, then waits a bounded time for the
//               result pulse; if none arrives the sample is dropped and ERR
//               pulses.
//
// Parameters  : DEPTH        sample FIFO entries (power of two, 2..8)
//               TIMEOUT      WAIT cycles before abort (1..31)
//
// Ports       : CLK          clock, rising edge
//               RST_N        asynchronous active-low reset
//               S_VALID      upstream sample valid
//               S_READY      FIFO not full, sample can be accepted
//               S_X, S_Y     signed 8-bit sample components
//               SQ_IN_VALID  one-cycle start pulse to square-root stage
//               SQ_IN        16-bit unsigned radicand X*X+Y*Y
//               SQ_OUT_VALID result pulse from square-root stage
//               BUSY         FSM not in IDLE
//               FIFO_CNT     FIFO occupancy 0..DEPTH
//               ERR          one-cycle pulse on WAIT timeout
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mag_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [7:0]  S_X,
  input  logic [7:0]  S_Y,
  output logic        SQ_IN_VALID,
  output logic [15:0] SQ_IN,
  input  logic        SQ_OUT_VALID,
  output logic        BUSY,
  output logic [3:0]  FIFO_CNT,
  output logic        ERR
);

  localparam int          c_aw      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  c_depth   = 4'(DEPTH);
  localparam logic [4:0]  c_to_last = 5'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [15:0]         r_mem [DEPTH];
  logic [c_aw-1:0]     r_wr_ptr;
  logic [c_aw-1:0]     r_rd_ptr;
  logic [3:0]          r_cnt;
  logic [7:0]          r_x;
  logic [7:0]          r_y;
  logic [15:0]         r_sq_in;
  logic                r_sq_in_valid;
  logic                r_err;
  logic [4:0]          r_to_cnt;

  // ---------------------------------------------------------------------------
  // Combinational
  // ---------------------------------------------------------------------------
  logic                w_ready;
  logic                w_push;
  logic                w_pop;
  logic [15:0]         w_head;
  logic [7:0]          w_ax;
  logic [7:0]          w_ay;
  logic [15:0]         w_sq_x;
  logic [15:0]         w_sq_y;

  // Readiness uses the registered count only, so a pop in the same cycle
  // never opens room for a push into a full FIFO.
  assign w_ready = (r_cnt != c_depth);
  assign w_push  = S_VALID && w_ready;
  assign w_pop   = (r_state == ST_IDLE) && (r_cnt != 4'd0);
  assign w_head  = r_mem[r_rd_ptr];

  // Square the magnitudes as unsigned values. |-128| = 128 still fits in
  // 8 unsigned bits, and 2*128^2 = 0x8000 fits in 16 bits, so no overflow.
  assign w_ax   = r_x[7] ? (~r_x + 8'd1) : r_x;
  assign w_ay   = r_y[7] ? (~r_y + 8'd1) : r_y;
  assign w_sq_x = 16'(w_ax) * 16'(w_ax);
  assign w_sq_y = 16'(w_ay) * 16'(w_ay);

  // ---------------------------------------------------------------------------
  // FIFO storage (data needs no reset; pointers and count do)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {S_X, S_Y};
    end
  end

  // Pointers are c_aw bits wide and DEPTH is a power of two, so they wrap
  // modulo DEPTH naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= 4'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 4'd1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM: IDLE -> CALC -> ISSUE -> WAIT -> IDLE
  // SQ_IN_VALID is set on the CALC->ISSUE edge so it is high exactly while
  // the FSM sits in ISSUE. SQ_IN is only written leaving CALC, so it stays
  // stable through ISSUE and WAIT for the stage that samples it late.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_IDLE;
      r_x           <= 8'd0;
      r_y           <= 8'd0;
      r_sq_in       <= 16'd0;
      r_sq_in_valid <= 1'b0;
      r_err         <= 1'b0;
      r_to_cnt      <= 5'd0;
    end else begin
      r_sq_in_valid <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_x     <= w_head[15:8];
            r_y     <= w_head[7:0];
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_sq_in       <= w_sq_x + w_sq_y;
          r_sq_in_valid <= 1'b1;
          r_state       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_to_cnt <= 5'd0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (SQ_OUT_VALID) begin
            r_state <= ST_IDLE;
          end else if (r_to_cnt == c_to_last) begin
            // TIMEOUT cycles spent in WAIT with no result: drop the sample.
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 5'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign S_READY     = w_ready;
  assign SQ_IN_VALID = r_sq_in_valid;
  assign SQ_IN       = r_sq_in;
  assign BUSY        = (r_state != ST_IDLE);
  assign FIFO_CNT    = r_cnt;
  assign ERR         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mag_feeder.sv
//==============================================================================
// Module      : tb_mag_feeder
// Description : Self-checking bench for mag_feeder. Expected radicands are
//               queued as samples are accepted and compared when the DUT
//               issues SQ_IN_VALID.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mag_feeder;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 31;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        S_VALID = 1'b0;
  logic [7:0]  S_X = 8'd0;
  logic [7:0]  S_Y = 8'd0;
  logic        SQ_OUT_VALID = 1'b0;
  logic        S_READY;
  logic        SQ_IN_VALID;
  logic [15:0] SQ_IN;
  logic        BUSY;
  logic [3:0]  FIFO_CNT;
  logic        ERR;

  mag_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .S_VALID      (S_VALID),
    .S_READY      (S_READY),
    .S_X          (S_X),
    .S_Y          (S_Y),
    .SQ_IN_VALID  (SQ_IN_VALID),
    .SQ_IN        (SQ_IN),
    .SQ_OUT_VALID (SQ_OUT_VALID),
    .BUSY         (BUSY),
    .FIFO_CNT     (FIFO_CNT),
    .ERR          (ERR)
  );

  always #5 CLK = ~CLK;

  int r_cyc = 0;
  always @(posedge CLK) r_cyc <= r_cyc + 1;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q [$];
  int          n_issue = 0;
  int          n_err = 0;
  int          issue_cyc = 0;
  int          err_cyc = 0;
  int          push_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_sq = 16'd0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] model_sq(input logic [7:0] x, input logic [7:0] y);
    int sx;
    int sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    return 16'(sx * sx + sy * sy);
  endfunction

  // Monitor: compares each issued radicand with the scoreboard head, checks
  // SQ_IN holds the cycle after the pulse, and logs ERR pulses.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (prev_valid) chk("sq_in_hold", SQ_IN, prev_sq);
      if (SQ_IN_VALID) begin
        n_issue++;
        issue_cyc = r_cyc;
        if (exp_q.size() == 0) chk("issue_with_empty_scoreboard", SQ_IN_VALID, 0);
        else chk("sq_in", SQ_IN, exp_q.pop_front());
      end
      if (ERR) begin
        n_err++;
        err_cyc = r_cyc;
      end
      prev_valid = SQ_IN_VALID;
      prev_sq    = SQ_IN;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the push edge.
  task automatic push(input logic [7:0] x, input logic [7:0] y, output logic acc);
    S_VALID = 1'b1;
    S_X     = x;
    S_Y     = y;
    @(negedge CLK);
    acc = S_READY;
    if (acc) exp_q.push_back(model_sq(x, y));
    @(posedge CLK);
    #1;
    push_cyc = r_cyc;
    S_VALID  = 1'b0;
  endtask

  task automatic wait_issue(input int budget);
    int start;
    int k;
    start = n_issue;
    k = 0;
    while (n_issue == start && k < budget) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk("issue_seen", n_issue - start, 1);
  endtask

  // Called at posedge+1 with the DUT in WAIT.
  task automatic respond();
    chk("busy_in_wait", BUSY, 1);
    SQ_OUT_VALID = 1'b1;
    @(posedge CLK);
    #1;
    SQ_OUT_VALID = 1'b0;
    @(negedge CLK);
    chk("busy_after_resp", BUSY, 0);
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] tab_x [5] = '{8'h80, 8'h00, 8'h7F, 8'hFF, 8'h64};
  logic [7:0] tab_y [5] = '{8'h80, 8'h00, 8'h81, 8'h05, 8'hFD};

  initial begin
    logic acc;
    int   start;
    int   start_err;
    int   t_issue;
    int   k;

    // Reset values
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_s_ready", S_READY, 1);
    chk("rst_fifo_cnt", FIFO_CNT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_sq_in_valid", SQ_IN_VALID, 0);
    chk("rst_sq_in", SQ_IN, 0);
    chk("rst_err", ERR, 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Basic (3,4) -> 25 with two-cycle latency
    push(8'd3, 8'd4, acc);
    chk("push_34_acc", acc, 1);
    wait_issue(10);
    chk("latency_34", issue_cyc - push_cyc, 2);
    respond();

    // Boundary and assorted operands
    for (int i = 0; i < 5; i++) begin
      push(tab_x[i], tab_y[i], acc);
      chk($sformatf("push_tab%0d_acc", i), acc, 1);
      wait_issue(10);
      chk($sformatf("latency_tab%0d", i), issue_cyc - push_cyc, 2);
      respond();
    end
    chk("no_err_yet", n_err, 0);

    // Fill with no response: one sample is popped into the FSM, DEPTH more
    // fill the FIFO, the next push is refused.
    start = n_issue;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(8'(i + 1), 8'(2 * i), acc);
      chk($sformatf("fill_acc%0d", i), acc, (i < DEPTH + 1) ? 1 : 0);
    end
    chk("full_cnt", FIFO_CNT, DEPTH);
    chk("full_ready", S_READY, 0);
    chk("fill_one_issued", n_issue - start, 1);
    t_issue = issue_cyc;

    // Timeout: ERR once after TIMEOUT WAIT cycles, then next entry issued
    start_err = n_err;
    k = 0;
    while (n_err == start_err && k < 60) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk("err_seen", n_err - start_err, 1);
    chk("err_delay", err_cyc - t_issue, TIMEOUT + 1);
    wait_issue(10);
    chk("reissue_gap", issue_cyc - err_cyc, 2);
    chk("err_once", n_err - start_err, 1);
    chk("cnt_after_reissue", FIFO_CNT, DEPTH - 1);

    // Reset in WAIT with entries queued
    RST_N = 1'b0;
    #1;
    chk("midrst_fifo_cnt", FIFO_CNT, 0);
    chk("midrst_sq_in_valid", SQ_IN_VALID, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_s_ready", S_READY, 1);
    chk("midrst_sq_in", SQ_IN, 0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    start = n_issue;
    repeat (10) @(posedge CLK);
    #1;
    chk("post_rst_no_issue", n_issue - start, 0);
    chk("post_rst_cnt", FIFO_CNT, 0);
    chk("post_rst_busy", BUSY, 0);

    // SQ_OUT_VALID in IDLE is ignored
    start_err = n_err;
    SQ_OUT_VALID = 1'b1;
    @(posedge CLK);
    #1;
    SQ_OUT_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("idle_resp_busy", BUSY, 0);
    chk("idle_resp_cnt", FIFO_CNT, 0);
    chk("idle_resp_no_issue", n_issue - start, 0);
    chk("idle_resp_no_err", n_err - start_err, 0);

    // Normal operation after reset
    push(8'hFD, 8'h04, acc);
    chk("post_rst_push_acc", acc, 1);
    wait_issue(10);
    chk("post_rst_latency", issue_cyc - push_cyc, 2);
    respond();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
